// File: rtl/reg_bank_pkg.sv
// Shared types and register indices for the reg_bank register file.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    MOD_NONE = 2'd0,
    MOD_INC  = 2'd1,
    MOD_DEC  = 2'd2,
    MOD_RSVD = 2'd3
  } mod_op_t;

  localparam int REG_A  = 0;
  localparam int REG_X  = 1;
  localparam int REG_Y  = 2;
  localparam int REG_SP = 3;

endpackage

// File: rtl/reg_bank_incdec.sv
// Combinational increment/decrement unit shared by all registers of reg_bank.
module incdec_unit
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  mod_op_t          op,
  output logic [WIDTH-1:0] result,
  output logic             wrap
);

  always_comb begin
    result = value;
    wrap   = 1'b0;
    case (op)
      MOD_INC: begin
        result = value + 1'b1;
        wrap   = &value;
      end
      MOD_DEC: begin
        result = value - 1'b1;
        wrap   = ~|value;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Parametrised register bank with write, in-place inc/dec, tri-state and plain read ports, and Z/N/C flags.
// Define OIS_EN to expose the flattened register contents on dbg_regs.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               NUM_REGS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SELW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [SELW-1:0]           wr_sel,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [1:0]                mod_op,
  input  logic [SELW-1:0]           mod_sel,
  input  logic [SELW-1:0]           rd_sel_a,
  input  logic                      rd_oe_a,
  output logic [WIDTH-1:0]          rd_data_a,
  input  logic [SELW-1:0]           rd_sel_b,
  output logic [WIDTH-1:0]          rd_data_b,
`ifdef OIS_EN
  output logic [NUM_REGS*WIDTH-1:0] dbg_regs,
`endif
  output logic                      flag_z,
  output logic                      flag_n,
  output logic                      flag_c
);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] val_a;
  logic [WIDTH-1:0] mod_val;
  logic [WIDTH-1:0] mod_res;
  logic             mod_wrap;
  logic             wr_ok;
  logic             mod_ok;
  logic             mod_act;
  mod_op_t          op;

  assign op     = mod_op_t'(mod_op);
  assign wr_ok  = wr_en && (32'(wr_sel) < NUM_REGS);
  assign mod_ok = (op == MOD_INC || op == MOD_DEC) && (32'(mod_sel) < NUM_REGS);
  // A write to the same register discards the modify entirely, including its flags.
  assign mod_act = mod_ok && !(wr_ok && wr_sel == mod_sel);

  // Out-of-range selects match no register and so read as zero.
  always_comb begin
    val_a     = '0;
    rd_data_b = '0;
    mod_val   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel_a == SELW'(i)) val_a = regs[i];
      if (rd_sel_b == SELW'(i)) rd_data_b = regs[i];
      if (mod_sel == SELW'(i)) mod_val = regs[i];
    end
  end

  assign rd_data_a = rd_oe_a ? val_a : {WIDTH{1'bz}};

  incdec_unit #(.WIDTH(WIDTH)) u_incdec (
    .value  (mod_val),
    .op     (op),
    .result (mod_res),
    .wrap   (mod_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      flag_z <= (RESET_VAL == '0);
      flag_n <= RESET_VAL[WIDTH-1];
      flag_c <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && wr_sel == SELW'(i))
          regs[i] <= wr_data;
        else if (mod_act && mod_sel == SELW'(i))
          regs[i] <= mod_res;
      end
      if (mod_act) begin
        flag_z <= (mod_res == '0);
        flag_n <= mod_res[WIDTH-1];
        flag_c <= mod_wrap;
      end else if (wr_ok) begin
        flag_z <= (wr_data == '0);
        flag_n <= wr_data[WIDTH-1];
        flag_c <= 1'b0;
      end
    end
  end

`ifdef OIS_EN
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_dbg
    assign dbg_regs[g*WIDTH +: WIDTH] = regs[g];
  end
`endif

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised successor to the single n-bit load/output-enable register.
- Holds NUM_REGS registers of WIDTH bits, for example A, X, Y and SP of the 6502 datapath.
- Provides one write port, an in-place increment/decrement port, one tri-state bus read port and one always-driven read port.
- Generates registered zero, negative and carry/borrow flags for the last value written or modified.

Parameters:
- WIDTH, 8, bit width of each register.
- NUM_REGS, 4, number of registers; need not be a power of 2.
- RESET_VAL, 0, value every register takes on reset (WIDTH bits).
- SELW, $clog2(NUM_REGS) with a minimum of 1, select width; derived, not to be overridden.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  load wr_data into register wr_sel.
- wr_sel  in  SELW  write target.
- wr_data  in  WIDTH  data to load.
- mod_op  in  2  in-place op: 0 NONE, 1 INC, 2 DEC, 3 reserved (treated as NONE).
- mod_sel  in  SELW  target of mod_op.
- rd_sel_a  in  SELW  bus read select.
- rd_oe_a  in  1  output enable for rd_data_a.
- rd_data_a  out  WIDTH  stored value of rd_sel_a when rd_oe_a=1, else all-Z.
- rd_sel_b  in  SELW  internal read select.
- rd_data_b  out  WIDTH  stored value of rd_sel_b, always driven.
- flag_z  out  1  last result == 0.
- flag_n  out  1  last result MSB.
- flag_c  out  1  last INC wrapped or last DEC borrowed.

Behaviour:
- Reset: one clock, asynchronous, active-high. While rst=1, regardless of clk:
  - all registers = RESET_VAL;
  - flag_z = (RESET_VAL==0), flag_n = RESET_VAL[WIDTH-1], flag_c = 0.
  - Reset asserted mid-operation overrides any write or modify in that cycle.
  - Release takes effect at the next rising edge with no extra latency.
- Reads:
  - Combinational from stored state; no write-through bypass.
  - A value written at edge k is visible on rd_data_* after edge k.
- Write:
  - wr_en=1 at the edge loads wr_data into register wr_sel.
  - Flags update from wr_data; flag_c is cleared.
- INC:
  - reg <= reg+1, modulo 2^WIDTH.
  - At all-ones the result is 0 and flag_c=1; otherwise flag_c=0.
- DEC:
  - reg <= reg-1, modulo 2^WIDTH.
  - At 0 the result is all-ones and flag_c=1 (borrow); otherwise flag_c=0.
- Simultaneous write and modify, same register: the write wins, mod_op is discarded and flags come from wr_data.
- Simultaneous write and modify, different registers: both take effect; flags come from the modify result.
- Flags hold their value in any cycle with no effective write or modify.
- Out-of-range select (index >= NUM_REGS):
  - a write or modify to it is ignored and flags hold;
  - reads return 0 (rd_data_a is still Z when rd_oe_a=0).
- rd_oe_a affects only port a and never changes state.

Optional Feature:
- Macro: OIS_EN (output internal state).
- Defined: adds output port dbg_regs, NUM_REGS*WIDTH bits wide, the flattened stored contents with register i at bits [i*WIDTH +: WIDTH]. It is always driven and is not tri-stated.
- Undefined: the port does not exist; behaviour is otherwise identical.

Decomposition:
- Package reg_bank_pkg holds:
  - mod_op_t enum: MOD_NONE=0, MOD_INC=1, MOD_DEC=2, MOD_RSVD=3;
  - constants REG_A=0, REG_X=1, REG_Y=2, REG_SP=3.
- Sub-module incdec_unit:
  - combinational, WIDTH-parametrised;
  - inputs: value, op;
  - outputs: result, wrap;
  - one instance, shared by all registers through mod_sel.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after loading X=0x42 -> all registers immediately read 0x00, flag_z=1, flag_n=0, flag_c=0.
- Write/read latency: wr_en, sel=A, data 0x80 -> next cycle rd_data_b(A)=0x80, flag_n=1, flag_z=0; with rd_oe_a=0, rd_data_a=Z.
- Wrap:
  - load SP=0xFF, INC -> SP=0x00, flag_c=1, flag_z=1;
  - then DEC -> SP=0xFF, flag_c=1, flag_n=1.
- Conflict:
  - same cycle, write Y=0x10 and INC Y -> Y=0x10, flag_c=0;
  - then write A=0x05 with DEC X (X=0x01) -> A=0x05, X=0x00, flag_z=1.
- Out of range (NUM_REGS=3, sel=3): write 0x55 -> no register changes, flags hold; read sel=3 -> 0x00.
- OIS_EN build: load A=0x11, X=0x22, Y=0x33, SP=0x44 -> dbg_regs=0x44332211.
